// File: rtl/program_loader.sv
// Boot-time loader: turns a little-endian byte stream (32-bit word-count header, then N words)
// into consecutive instruction-memory writes, then releases the core or flags an oversize image.
module program_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [63:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             core_run,
  output logic             load_error,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {HDR, DATA, WRITE, DONE, ERROR} state_t;

  state_t           state, state_next;
  logic [1:0]       byte_cnt;
  logic [31:0]      n_words;
  logic [CNT_W-1:0] count;
  logic             take;
  logic [31:0]      hdr_full;

  // rx_ready is forced low while reset is held, so only the state decode matters afterwards.
  assign rx_ready     = rst_n & ((state == HDR) | (state == DATA));
  assign take         = rx_valid & rx_ready;
  assign hdr_full     = {rx_data, n_words[23:0]};
  assign imem_we      = (state == WRITE);
  assign core_run     = (state == DONE);
  assign load_error   = (state == ERROR);
  assign words_loaded = count;
  assign imem_waddr   = {{(64 - CNT_W - 2){1'b0}}, count, 2'b00};

  always_comb begin
    state_next = state;
    unique case (state)
      HDR: begin
        if (take && byte_cnt == 2'd3) begin
          if (hdr_full == 32'd0)       state_next = DONE;
          else if (hdr_full > DEPTH)   state_next = ERROR;
          else                         state_next = DATA;
        end
      end
      DATA: begin
        if (take && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        if (32'(count) + 32'd1 == n_words) state_next = DONE;
        else                                state_next = DATA;
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR;
      byte_cnt   <= '0;
      n_words    <= '0;
      count      <= '0;
      imem_wdata <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        byte_cnt <= byte_cnt + 2'd1;
        // Lanes are filled in place; all four are rewritten before the word is presented.
        if (state == HDR) n_words[8*byte_cnt +: 8]    <= rx_data;
        else              imem_wdata[8*byte_cnt +: 8] <= rx_data;
      end
      if (state == WRITE) count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against an image-level reference model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_run;
  logic        load_error;
  logic [15:0] words_loaded;

  program_loader #(.DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_run(core_run), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: every write observed, plus cycle stamps for the core_run timing rule.
  logic [95:0] wq[$];
  int ncyc = 0;
  int last_we = -1;
  int cr_first = -1;
  always @(negedge clk) begin
    ncyc++;
    if (imem_we) begin
      wq.push_back({imem_waddr, imem_wdata});
      last_we = ncyc;
    end
    if (core_run && cr_first < 0) cr_first = ncyc;
  end

  // Reference model output
  logic [95:0] exp_q[$];
  int exp_acc;
  bit exp_err;
  bit exp_run;
  int exp_n;

  task automatic model(input logic [7:0] b[$]);
    logic [31:0] n;
    exp_q.delete();
    n = {b[3], b[2], b[1], b[0]};
    exp_err = 1'b0;
    exp_run = 1'b0;
    exp_acc = 4;
    exp_n = 0;
    if (n == 0) exp_run = 1'b1;
    else if (n > 64) exp_err = 1'b1;
    else begin
      exp_run = 1'b1;
      exp_n = int'(n);
      exp_acc = 4 + 4 * exp_n;
      for (int k = 0; k < exp_n; k++)
        exp_q.push_back({64'(4 * k), b[4*k+7], b[4*k+6], b[4*k+5], b[4*k+4]});
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    last_we = -1;
    cr_first = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers bytes in order, re-offering a byte until it is taken; gaps drop rx_valid.
  task automatic send(input logic [7:0] q[$], input int gap_pct, output int accepted);
    int budget;
    bit v, r;
    accepted = 0;
    budget = q.size() * 8 + 40;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (accepted < q.size() && int'($urandom_range(99)) >= gap_pct) begin
        rx_valid = 1'b1;
        rx_data = q[accepted];
      end else begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
      end
      v = rx_valid;
      r = rx_ready;
      @(posedge clk);
      if (v && r) accepted++;
      if (accepted == q.size()) break;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_image(input string name, input logic [7:0] q[$], input int gap_pct);
    int acc;
    model(q);
    send(q, gap_pct, acc);
    repeat (4) @(negedge clk);
    checks++;
    if (acc !== exp_acc) begin
      errors++; $display("FAIL %s accepted: got %0d expected %0d", name, acc, exp_acc);
    end
    checks++;
    if (wq.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s write_count: got %0d expected %0d", name, wq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr %h data %h expected addr %h data %h",
                 name, i, wq[i][95:32], wq[i][31:0], exp_q[i][95:32], exp_q[i][31:0]);
      end
    end
    checks++;
    if (core_run !== exp_run || load_error !== exp_err) begin
      errors++;
      $display("FAIL %s status: got run %b err %b expected run %b err %b",
               name, core_run, load_error, exp_run, exp_err);
    end
    checks++;
    if (words_loaded !== 16'(exp_n)) begin
      errors++; $display("FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, exp_n);
    end
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL %s rx_ready_after: got %b expected 0", name, rx_ready);
    end
    if (exp_n > 0) begin
      checks++;
      if (cr_first !== last_we + 1) begin
        errors++;
        $display("FAIL %s core_run_timing: got cycle %0d expected %0d", name, cr_first, last_we + 1);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (rx_ready !== 1'b0 || imem_we !== 1'b0 || imem_waddr !== 64'd0 || imem_wdata !== 32'd0 ||
        core_run !== 1'b0 || load_error !== 1'b0 || words_loaded !== 16'd0) begin
      errors++;
      $display("FAIL %s reset_vals: got rdy %b we %b addr %h data %h run %b err %b words %0d expected all 0",
               name, rx_ready, imem_we, imem_waddr, imem_wdata, core_run, load_error, words_loaded);
    end
  endtask

  function automatic void basic_stream(output logic [7:0] q[$]);
    q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset rx_ready_release: got %b expected 1", rx_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q[$];
    do_reset();
    basic_stream(q);
    check_image("basic", q, 0);
    // Bytes offered after completion must never be taken.
    do_reset();
    basic_stream(q);
    q.push_back(8'hDE);
    q.push_back(8'hAD);
    check_image("basic_extra", q, 0);
  endtask

  // Manually streams a header and checks the status changes exactly one cycle after the 4th byte.
  task automatic test_header(input string name, input logic [31:0] n, input bit want_err);
    logic [31:0] hv;
    hv = n;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = hv[8*i +: 8];
      checks++;
      if (core_run !== 1'b0 || load_error !== 1'b0 || rx_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s early[%0d]: got run %b err %b rdy %b expected 0 0 1",
                 name, i, core_run, load_error, rx_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (core_run !== !want_err || load_error !== want_err || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got run %b err %b rdy %b expected %b %b 0",
               name, core_run, load_error, rx_ready, !want_err, want_err);
    end
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (wq.size() !== 0 || rx_ready !== 1'b0 || core_run !== !want_err) begin
      errors++;
      $display("FAIL %s held: got writes %0d rdy %b run %b expected 0 0 %b",
               name, wq.size(), rx_ready, core_run, !want_err);
    end
  endtask

  task automatic test_stress();
    logic [7:0] q[$];
    for (int it = 0; it < 3; it++) begin
      do_reset();
      basic_stream(q);
      check_image("stress_basic", q, 40);
    end
  endtask

  task automatic test_random_images();
    logic [7:0] q[$];
    int n;
    for (int it = 0; it < 4; it++) begin
      n = int'($urandom_range(1, 9));
      if (it == 3) n = 64;
      q.delete();
      q.push_back(8'(n));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
      for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
      do_reset();
      check_image("random_image", q, (it % 2 == 0) ? 30 : 0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] q[$];
    int acc;
    do_reset();
    basic_stream(q);
    q = q[0:8];
    send(q, 0, acc);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midload");
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    basic_stream(q);
    check_image("midload_reload", q, 20);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_header("empty", 32'd0, 1'b0);
    test_header("oversize65", 32'd65, 1'b1);
    test_header("oversize_msb", 32'h8000_0000, 1'b1);
    test_stress();
    test_random_images();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
